arith_nibble_sequencer: RTL and testbench

- Sequential front/back-end for the team's 4-bit combinational arithmetic unit (ports A[3:0], B[3:0], S[1:0], Cin; results D[3:0], Cout).
- Accepts wide operands plus a 2-bit op code over a start/ready handshake.
- Drives the unit one nibble per clock, LSB nibble first, chaining the registered carry between nibbles.
- Captures each result nibble, then presents the full-width result, carry-out and signed overflow with a one-cycle valid pulse.

---
 rtl/arith_nibble_sequencer.sv | 134 +++++++++++++
 tb/tb_arith_nibble_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/arith_nibble_sequencer.sv
// arith_nibble_sequencer
// Feeds wide operands through the external 4-bit arithmetic unit one nibble
// per clock, LSB nibble first, chaining the carry between nibbles. It then
// presents the assembled result, the carry-out and the signed overflow with
// a one-cycle valid pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready=1; waiting for start; operands latched on acceptance
// RUN   | one nibble per clock through the unit; carry held in carry_reg
// DONE  | valid=1 for one cycle; result/cout/ovf final; back to IDLE
module arith_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [1:0]             op,
   input  logic                   cin_in,
   input  logic [4*NIBBLES-1:0]   a_in,
   input  logic [4*NIBBLES-1:0]   b_in,
   output logic                   ready,
   output logic [3:0]             au_A,
   output logic [3:0]             au_B,
   output logic [1:0]             au_S,
   output logic                   au_Cin,
   input  logic [3:0]             au_D,
   input  logic                   au_Cout,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   ovf,
   output logic                   valid
);

   localparam int DW = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic            carry_reg;
   logic [DW-1:0]   a_reg;
   logic [DW-1:0]   b_reg;
   logic [1:0]      op_reg;

   logic            ea3;
   logic            eb3;
   logic            c_msb;
   logic            ovf_next;

   // Slice the latched operands for the current nibble; registers are cleared
   // at reset so these read zero until the first acceptance.
   always_comb begin
      au_A   = a_reg[{idx, 2'b00} +: 4];
      au_B   = b_reg[{idx, 2'b00} +: 4];
      au_S   = op_reg;
      au_Cin = carry_reg;
   end

   // Signed overflow from the top nibble: reconstruct the operand sign bits as
   // the unit sees them after its own inversions, recover the carry into the
   // MSB from the sum bit, and compare it with the carry out of the MSB.
   always_comb begin
      ea3 = 1'b0;
      eb3 = 1'b0;
      case (op_reg)
         2'b00:   begin ea3 =  a_reg[DW-1]; eb3 =  b_reg[DW-1]; end
         2'b01:   begin ea3 =  a_reg[DW-1]; eb3 = ~b_reg[DW-1]; end
         2'b10:   begin ea3 = ~a_reg[DW-1]; eb3 =  b_reg[DW-1]; end
         default: begin ea3 = 1'b0;         eb3 = ~b_reg[DW-1]; end
      endcase
      c_msb    = au_D[3] ^ ea3 ^ eb3;
      ovf_next = c_msb ^ au_Cout;
   end

   // Sequencer FSM with registered ready/valid and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ready     <= 1'b1;
         valid     <= 1'b0;
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= 2'b00;
         result    <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && ready) begin
                  a_reg     <= a_in;
                  b_reg     <= b_in;
                  op_reg    <= op;
                  carry_reg <= cin_in;
                  idx       <= '0;
                  state     <= S_RUN;
                  ready     <= 1'b0;
               end
            end
            S_RUN: begin
               result[{idx, 2'b00} +: 4] <= au_D;
               carry_reg                 <= au_Cout;
               if (idx == LAST_IDX) begin
                  cout  <= au_Cout;
                  ovf   <= ovf_next;
                  valid <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arith_nibble_sequencer.sv
// tb_arith_nibble_sequencer
// Directed vectors with hand-computed expectations; the 4-bit arithmetic unit
// is modelled combinationally in the bench.
module tb_arith_nibble_sequencer;

   localparam int NIBBLES = 4;
   localparam int DW = 4 * NIBBLES;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic          cin_in;
   logic [DW-1:0] a_in;
   logic [DW-1:0] b_in;
   logic          ready;
   logic [3:0]    au_A;
   logic [3:0]    au_B;
   logic [1:0]    au_S;
   logic          au_Cin;
   logic [3:0]    au_D;
   logic          au_Cout;
   logic [DW-1:0] result;
   logic          cout;
   logic          ovf;
   logic          valid;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [NIBBLES-1:0] cin_trace;
   logic [3:0]         first_au_a;
   int                 acc_cyc;
   int                 prev_acc;
   logic               keep_start;
   int                 valid_seen;

   arith_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .cin_in  (cin_in),
      .a_in    (a_in),
      .b_in    (b_in),
      .ready   (ready),
      .au_A    (au_A),
      .au_B    (au_B),
      .au_S    (au_S),
      .au_Cin  (au_Cin),
      .au_D    (au_D),
      .au_Cout (au_Cout),
      .result  (result),
      .cout    (cout),
      .ovf     (ovf),
      .valid   (valid)
   );

   // 4-bit arithmetic unit model
   logic [3:0] ea;
   logic [3:0] eb;
   always_comb begin
      ea = au_A;
      eb = au_B;
      case (au_S)
         2'b00:   begin ea = au_A;  eb = au_B;  end
         2'b01:   begin ea = au_A;  eb = ~au_B; end
         2'b10:   begin ea = ~au_A; eb = au_B;  end
         default: begin ea = 4'h0;  eb = ~au_B; end
      endcase
      {au_Cout, au_D} = {1'b0, ea} + {1'b0, eb} + {4'b0000, au_Cin};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Starts one run from IDLE, waits (bounded) for valid and checks the
   // latency, ready-low span and final outputs. Returns one cycle after valid.
   task automatic run_check(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [1:0] o, input logic ci, input logic [DW-1:0] exp_res,
                            input logic exp_cout, input logic exp_ovf);
      int n;
      int rlow;
      a_in = a; b_in = b; op = o; cin_in = ci; start = 1'b1;
      @(posedge clk);
      acc_cyc = cyc;
      #1;
      start  = keep_start;
      a_in   = ~a; b_in = ~b; op = ~o; cin_in = ~ci;
      cin_trace  = '0;
      cin_trace[0] = au_Cin;
      first_au_a = au_A;
      rlow = (ready == 1'b0) ? 1 : 0;
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (ready == 1'b0) rlow++;
         if (valid) break;
         if (n < NIBBLES) cin_trace[n] = au_Cin;
      end
      check_eq({tag, "_latency"}, n, NIBBLES);
      check_eq({tag, "_ready_low"}, rlow, NIBBLES + 1);
      check_eq({tag, "_result"}, result, exp_res);
      check_eq({tag, "_cout"}, cout, exp_cout);
      check_eq({tag, "_ovf"}, ovf, exp_ovf);
      @(posedge clk); #1;
      check_eq({tag, "_valid_drop"}, valid, 1'b0);
      check_eq({tag, "_ready_back"}, ready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'b00; cin_in = 1'b0;
      a_in = '0; b_in = '0; keep_start = 1'b0;
      #12;
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_valid", valid, 1'b0);
      check_eq("rst_result", result, 16'h0000);
      check_eq("rst_cout_ovf", {cout, ovf}, 2'b00);
      check_eq("rst_au", {au_A, au_B, au_S, au_Cin}, 11'h000);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: plain add
      run_check("t1_add", 16'h1234, 16'h0FFF, 2'b00, 1'b0, 16'h2233, 1'b0, 1'b0);

      // 2: subtract with borrow, carry chain into each nibble
      run_check("t2_sub", 16'h0005, 16'h0007, 2'b01, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      check_eq("t2_cin_trace", cin_trace, 4'b0001);

      // 3: carry out, then signed overflow
      run_check("t3_wrap", 16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_check("t3_ovf", 16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b1);

      // 4: negate B, A ignored but still driven on au_A
      run_check("t4_neg", 16'hABCD, 16'h0001, 2'b11, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      check_eq("t4_au_a_nib0", first_au_a, 4'hD);

      // 5a: start held through RUN and DONE is ignored
      keep_start = 1'b1;
      run_check("t5_extra_start", 16'h1111, 16'h2222, 2'b00, 1'b0, 16'h3333, 1'b0, 1'b0);
      start = 1'b0;
      keep_start = 1'b0;
      @(posedge clk); #1;
      check_eq("t5_no_accept", ready, 1'b1);
      check_eq("t5_result_held", result, 16'h3333);

      // 5b: asynchronous reset after nibble 1
      a_in = 16'h4444; b_in = 16'h1111; op = 2'b00; cin_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check_eq("t5_partial", result[7:0], 8'h55);
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_ready", ready, 1'b1);
      check_eq("t5_rst_result", result, 16'h0000);
      check_eq("t5_rst_valid", valid, 1'b0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      valid_seen = 0;
      for (int i = 0; i < NIBBLES + 4; i++) begin
         @(posedge clk); #1;
         if (valid) valid_seen++;
      end
      check_eq("t5_no_valid", valid_seen, 0);
      run_check("t5_fresh", 16'h0102, 16'h0304, 2'b00, 1'b1, 16'h0407, 1'b0, 1'b0);

      // 6: back-to-back with start held high
      keep_start = 1'b1;
      run_check("t6_r0", 16'h0001, 16'h0002, 2'b00, 1'b0, 16'h0003, 1'b0, 1'b0);
      prev_acc = acc_cyc;
      run_check("t6_r1", 16'h8000, 16'h0001, 2'b01, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      check_eq("t6_gap1", acc_cyc - prev_acc, NIBBLES + 2);
      prev_acc = acc_cyc;
      run_check("t6_r2", 16'h1234, 16'h0001, 2'b10, 1'b1, 16'hEDCD, 1'b0, 1'b0);
      check_eq("t6_gap2", acc_cyc - prev_acc, NIBBLES + 2);
      start = 1'b0;
      keep_start = 1'b0;

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got stuck expected finish");
      $fatal(1);
   end

endmodule
